// File: rtl/wb_stage_buf.sv
// Elastic MEM/WB stage: two-entry skid buffer carrying the write-back bundle.
// in_ready is registered, so there is no combinational path from out_ready back into MEM.
module wb_stage_buf #(
    parameter int DATA_W = 16,
    parameter int RID_W  = 3,
    parameter int SPEC_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SPEC_W-1:0] in_wspec,
    input  logic              in_memtoreg,
    input  logic              in_regwrite,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [RID_W-1:0]  in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SPEC_W-1:0] out_wspec,
    output logic              out_memtoreg,
    output logic              out_regwrite,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] out_alu,
    output logic [RID_W-1:0]  out_rd,
    output logic [DATA_W-1:0] out_result,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [1:0]        dbg_state
);

    localparam int BW = SPEC_W + 2 + 2 * DATA_W + RID_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_in_ready;
    logic [BW-1:0]    r_m;
    logic [BW-1:0]    r_s;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_out_valid;
    logic             w_accept;
    logic             w_consume;
    logic             w_load_m_in;
    logic             w_load_m_s;
    logic             w_load_s;
    logic [BW-1:0]    w_in_bundle;
    logic [SPEC_W-1:0] w_m_wspec;
    logic             w_m_regwrite;

    assign w_in_bundle = {in_wspec, in_memtoreg, in_regwrite, in_data, in_alu, in_rd};
    assign w_out_valid = (r_state != EMPTY);
    assign w_accept    = in_valid & r_in_ready;
    assign w_consume   = w_out_valid & out_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != FULL);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_m_in = 1'b0;
        w_load_m_s  = 1'b0;
        w_load_s    = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ONE;
                    w_load_m_in = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && w_consume) begin
                    w_load_m_in = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = FULL;
                    w_load_s    = 1'b1;
                end else if (w_consume) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_consume) begin
                    w_state_nxt = ONE;
                    w_load_m_s  = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
        // Flush overrides everything; a same-cycle consume needs no action since the head is gone.
        if (flush) begin
            w_state_nxt = EMPTY;
            w_load_m_in = 1'b0;
            w_load_m_s  = 1'b0;
            w_load_s    = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_m <= '0;
            r_s <= '0;
        end else begin
            if (w_load_m_in) begin
                r_m <= w_in_bundle;
            end else if (w_load_m_s) begin
                r_m <= r_s;
            end
            if (w_load_s) begin
                r_s <= w_in_bundle;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign {w_m_wspec, out_memtoreg, w_m_regwrite, out_data, out_alu, out_rd} = r_m;

    assign in_ready     = r_in_ready;
    assign out_valid    = w_out_valid;
    assign out_wspec    = w_out_valid ? w_m_wspec : '0;
    assign out_regwrite = w_out_valid & w_m_regwrite;
    assign out_result   = out_memtoreg ? out_data : out_alu;
    assign stall_cnt    = r_stall_cnt;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_wb_stage_buf.sv
// Bench for wb_stage_buf: a depth-2 FIFO model drives per-cycle comparisons,
// with directed phases pinned by literal expectations and a randomized phase.
module tb_wb_stage_buf;

    typedef struct packed {
        logic [1:0]  wspec;
        logic        memtoreg;
        logic        regwrite;
        logic [15:0] data;
        logic [15:0] alu;
        logic [2:0]  rd;
    } bun_t;

    logic        CLK, RST, flush, in_valid, out_ready;
    logic [1:0]  in_wspec;
    logic        in_memtoreg, in_regwrite;
    logic [15:0] in_data, in_alu;
    logic [2:0]  in_rd;

    logic        in_ready, out_valid, out_memtoreg, out_regwrite;
    logic [1:0]  out_wspec, dbg_state;
    logic [15:0] out_data, out_alu, out_result, stall_cnt;
    logic [2:0]  out_rd;

    logic        s_in_ready, s_out_valid, s_out_memtoreg, s_out_regwrite;
    logic [1:0]  s_out_wspec, s_dbg_state;
    logic [15:0] s_out_data, s_out_alu, s_out_result;
    logic [3:0]  s_stall_cnt;
    logic [2:0]  s_out_rd;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    bun_t q[$];
    int   cnt = 0;

    wb_stage_buf dut (
        .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_wspec(in_wspec), .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite),
        .in_data(in_data), .in_alu(in_alu), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_wspec(out_wspec),
        .out_memtoreg(out_memtoreg), .out_regwrite(out_regwrite), .out_data(out_data),
        .out_alu(out_alu), .out_rd(out_rd), .out_result(out_result),
        .stall_cnt(stall_cnt), .dbg_state(dbg_state)
    );

    wb_stage_buf #(.CNT_W(4)) dut_sat (
        .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_wspec(in_wspec), .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite),
        .in_data(in_data), .in_alu(in_alu), .in_rd(in_rd),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_wspec(s_out_wspec),
        .out_memtoreg(s_out_memtoreg), .out_regwrite(s_out_regwrite), .out_data(s_out_data),
        .out_alu(s_out_alu), .out_rd(s_out_rd), .out_result(s_out_result),
        .stall_cnt(s_stall_cnt), .dbg_state(s_dbg_state)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two bundles, updated on each rising edge.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            q.delete();
            cnt = 0;
        end else begin
            bit acc, cons;
            acc  = in_valid && (q.size() < 2);
            cons = (q.size() > 0) && out_ready;
            if ((q.size() > 0) && !out_ready) cnt++;
            if (flush) begin
                q.delete();
            end else begin
                if (cons) void'(q.pop_front());
                if (acc) q.push_back({in_wspec, in_memtoreg, in_regwrite, in_data, in_alu, in_rd});
            end
        end
    end

    always @(negedge CLK) begin
        if (!RST && cmp_en) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
            chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
            if (q.size() > 0) begin
                chk("wspec", {30'd0, out_wspec}, {30'd0, q[0].wspec});
                chk("memtoreg", {31'd0, out_memtoreg}, {31'd0, q[0].memtoreg});
                chk("regwrite", {31'd0, out_regwrite}, {31'd0, q[0].regwrite});
                chk("data", {16'd0, out_data}, {16'd0, q[0].data});
                chk("alu", {16'd0, out_alu}, {16'd0, q[0].alu});
                chk("rd", {29'd0, out_rd}, {29'd0, q[0].rd});
                chk("result", {16'd0, out_result},
                    {16'd0, q[0].memtoreg ? q[0].data : q[0].alu});
            end else begin
                chk("gate_regwrite", {31'd0, out_regwrite}, 32'd0);
                chk("gate_wspec", {30'd0, out_wspec}, 32'd0);
            end
            chk("stall_cnt", {16'd0, stall_cnt}, (cnt > 65535) ? 32'd65535 : cnt);
            chk("stall_cnt_sat", {28'd0, s_stall_cnt}, (cnt > 15) ? 32'd15 : cnt);
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input bit v, input bun_t b);
        in_valid    = v;
        in_wspec    = b.wspec;
        in_memtoreg = b.memtoreg;
        in_regwrite = b.regwrite;
        in_data     = b.data;
        in_alu      = b.alu;
        in_rd       = b.rd;
    endtask

    function automatic bun_t rnd_bun();
        bun_t b;
        b.wspec    = 2'($urandom_range(0, 3));
        b.memtoreg = 1'($urandom_range(0, 1));
        b.regwrite = 1'($urandom_range(0, 1));
        b.data     = 16'($urandom);
        b.alu      = 16'($urandom);
        b.rd       = 3'($urandom_range(0, 7));
        return b;
    endfunction

    initial begin
        bun_t b;
        RST = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        send(1'b0, '0);
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_alu", {16'd0, out_alu}, 32'd0);
        chk("rst_result", {16'd0, out_result}, 32'd0);
        chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        cmp_en = 1'b1;
        cyc();

        // Streaming at full throughput
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            b = rnd_bun();
            b.alu = 16'(i);
            b.rd  = 3'(i % 8);
            send(1'b1, b);
            cyc();
            chk("stream_alu", {16'd0, out_alu}, i);
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
        end
        send(1'b0, '0);
        cyc();
        chk("stream_stall", {16'd0, stall_cnt}, 32'd0);

        // Back-pressure: A, B fill the buffer, C is held off
        out_ready = 1'b0;
        b = rnd_bun(); b.alu = 16'h1111; send(1'b1, b); cyc();
        chk("bp_a_head", {16'd0, out_alu}, 32'h1111);
        b = rnd_bun(); b.alu = 16'h2222; send(1'b1, b); cyc();
        chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
        b = rnd_bun(); b.alu = 16'h3333; send(1'b1, b); cyc(); cyc();
        chk("bp_hold_head", {16'd0, out_alu}, 32'h1111);
        chk("bp_stall3", {16'd0, stall_cnt}, 32'd3);
        out_ready = 1'b1;
        cyc();
        chk("bp_b_head", {16'd0, out_alu}, 32'h2222);
        cyc();
        chk("bp_c_head", {16'd0, out_alu}, 32'h3333);
        send(1'b0, '0);
        cyc();
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // Result mux
        b = '0; b.memtoreg = 1'b1; b.data = 16'hBEEF; b.alu = 16'h1234; b.regwrite = 1'b1;
        send(1'b1, b); cyc();
        chk("mux_mem", {16'd0, out_result}, 32'hBEEF);
        b.memtoreg = 1'b0;
        send(1'b1, b); cyc();
        chk("mux_alu", {16'd0, out_result}, 32'h1234);
        send(1'b0, '0); cyc();

        // Flush while FULL with a bundle offered
        out_ready = 1'b0;
        b = rnd_bun(); b.regwrite = 1'b1; send(1'b1, b); cyc();
        b = rnd_bun(); send(1'b1, b); cyc();
        b = rnd_bun(); b.alu = 16'hDEAD; b.regwrite = 1'b1;
        send(1'b1, b); flush = 1'b1; cyc();
        flush = 1'b0; send(1'b0, '0);
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_regwrite", {31'd0, out_regwrite}, 32'd0);
        chk("flush_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (3) begin
            cyc();
            chk("flush_no_ghost", {31'd0, out_valid}, 32'd0);
        end

        // Saturation: 20 stalled cycles on top of the 5 so far
        out_ready = 1'b0;
        b = rnd_bun(); send(1'b1, b); cyc();
        send(1'b0, '0);
        repeat (20) cyc();
        chk("sat_stop15", {28'd0, s_stall_cnt}, 32'd15);
        chk("sat_wide25", {16'd0, stall_cnt}, 32'd25);
        out_ready = 1'b1;
        cyc();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            b = rnd_bun();
            send(1'(($urandom_range(0, 3)) != 0), b);
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 15) == 0);
            cyc();
        end
        flush = 1'b0;

        // Asynchronous reset between edges while FULL
        out_ready = 1'b0;
        b = rnd_bun(); send(1'b1, b); cyc();
        b = rnd_bun(); send(1'b1, b); cyc();
        if (in_ready !== 1'b0) begin
            b = rnd_bun(); send(1'b1, b); cyc();
        end
        send(1'b0, '0);
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_alu", {16'd0, out_alu}, 32'd0);
        chk("arst_data", {16'd0, out_data}, 32'd0);
        chk("arst_rd", {29'd0, out_rd}, 32'd0);
        chk("arst_result", {16'd0, out_result}, 32'd0);
        chk("arst_stall", {16'd0, stall_cnt}, 32'd0);
        @(posedge CLK);
        #3;
        RST = 1'b0;
        b = rnd_bun(); b.alu = 16'h5A5A; send(1'b1, b);
        out_ready = 1'b1;
        cyc();
        chk("arst_first_valid", {31'd0, out_valid}, 32'd1);
        chk("arst_first_alu", {16'd0, out_alu}, 32'h5A5A);
        send(1'b0, '0);
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
